rr_arbiter4: RTL and testbench

Four-requester round-robin arbiter that shares a single resource, such as a bus or functional unit, among four clients. It issues a registered one-hot grant together with the equivalent 2-bit index and enable, matching the index/enable/one-hot form our 2-to-4 decoders use. Grants are held until the owner drops its request or an optional hold limit expires. There is always one idle cycle between ownerships.

---
 rtl/rr_arbiter4.sv | 81 ++++++++
 tb/tb_rr_arbiter4.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a registered one-hot grant plus index/enable,
// an optional per-ownership hold limit, and one idle cycle between ownerships.
module rr_arbiter4 #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid,
   output logic       timeout
);

   localparam int CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
   localparam bit LIMIT_ON = (MAX_HOLD != 0);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]       state;
   logic [1:0]       ptr;
   logic [CNT_W-1:0] holdCnt;
   logic [7:0]       reqTwice;
   logic [3:0]       reqRot;
   logic [1:0]       offset;
   logic [1:0]       winner;

   // Rotate requests so the pointer position sits at bit 0, then pick the lowest set bit.
   assign reqTwice = {req, req};
   assign reqRot   = reqTwice[ptr +: 4];

   always_comb begin
      offset = 2'd0;
      if (reqRot[0])      offset = 2'd0;
      else if (reqRot[1]) offset = 2'd1;
      else if (reqRot[2]) offset = 2'd2;
      else if (reqRot[3]) offset = 2'd3;
      winner = ptr + offset;
   end

   // Arbitration happens only in IDLE; BUSY just watches the owner and the hold limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 2'd0;
         holdCnt   <= '0;
         gnt       <= 4'b0000;
         gnt_idx   <= 2'b00;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt       <= 4'b0001 << winner;
                  gnt_idx   <= winner;
                  gnt_valid <= 1'b1;
                  holdCnt   <= '0;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (!req[gnt_idx] || (LIMIT_ON && holdCnt == HOLD_LAST)) begin
                  gnt       <= 4'b0000;
                  gnt_valid <= 1'b0;
                  ptr       <= gnt_idx + 2'd1;
                  state     <= IDLE;
                  timeout   <= req[gnt_idx];
               end else if (LIMIT_ON) begin
                  holdCnt <= holdCnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench: two arbiters (MAX_HOLD=4 and MAX_HOLD=0) share one stimulus stream
// and are compared every cycle against an ownership-level reference model.
module tb_rr_arbiter4;

   logic       clk;
   logic       rst;
   logic [3:0] req;

   logic [3:0] gntA, gntB;
   logic [1:0] idxA, idxB;
   logic       validA, validB;
   logic       toA, toB;

   int checks;
   int errors;

   int mMaxHold [2];
   int mOwner   [2];
   int mCnt     [2];
   int mPtr     [2];
   int mIdx     [2];
   int mTo      [2];

   rr_arbiter4 #(.MAX_HOLD(4)) dutA (
      .clk(clk), .rst(rst), .req(req),
      .gnt(gntA), .gnt_idx(idxA), .gnt_valid(validA), .timeout(toA)
   );

   rr_arbiter4 #(.MAX_HOLD(0)) dutB (
      .clk(clk), .rst(rst), .req(req),
      .gnt(gntB), .gnt_idx(idxB), .gnt_valid(validB), .timeout(toB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: tracks who owns the resource and for how long, applied once per edge.
   task automatic modelStep(input int k, input logic [3:0] r, input logic rs);
      if (rs) begin
         mOwner[k] = -1; mPtr[k] = 0; mCnt[k] = 0; mIdx[k] = 0; mTo[k] = 0;
      end else if (mOwner[k] < 0) begin
         mTo[k] = 0;
         for (int j = 0; j < 4; j++)
            if (mOwner[k] < 0 && r[(mPtr[k] + j) % 4]) mOwner[k] = (mPtr[k] + j) % 4;
         if (mOwner[k] >= 0) begin
            mIdx[k] = mOwner[k];
            mCnt[k] = 1;
         end
      end else if (!r[mOwner[k]]) begin
         mPtr[k] = (mOwner[k] + 1) % 4; mOwner[k] = -1; mTo[k] = 0;
      end else if (mMaxHold[k] != 0 && mCnt[k] >= mMaxHold[k]) begin
         mPtr[k] = (mOwner[k] + 1) % 4; mOwner[k] = -1; mTo[k] = 1;
      end else begin
         mCnt[k] = mCnt[k] + 1;
         mTo[k]  = 0;
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [3:0] oGnt [2];
      logic [1:0] oIdx [2];
      logic       oVal [2];
      logic       oTo  [2];
      logic [3:0] eGnt;
      oGnt[0] = gntA; oIdx[0] = idxA; oVal[0] = validA; oTo[0] = toA;
      oGnt[1] = gntB; oIdx[1] = idxB; oVal[1] = validB; oTo[1] = toB;
      for (int k = 0; k < 2; k++) begin
         eGnt = (mOwner[k] >= 0) ? (4'b0001 << mOwner[k]) : 4'b0000;
         checks++;
         assert (oGnt[k] === eGnt) else begin
            errors++;
            $error("[TB] FAIL %s dut%0d gnt observed=%b expected=%b", tag, k, oGnt[k], eGnt);
         end
         checks++;
         assert (oVal[k] === (mOwner[k] >= 0)) else begin
            errors++;
            $error("[TB] FAIL %s dut%0d gnt_valid observed=%b expected=%b", tag, k, oVal[k], mOwner[k] >= 0);
         end
         checks++;
         assert (oIdx[k] === 2'(mIdx[k])) else begin
            errors++;
            $error("[TB] FAIL %s dut%0d gnt_idx observed=%0d expected=%0d", tag, k, oIdx[k], mIdx[k]);
         end
         checks++;
         assert (oTo[k] === 1'(mTo[k])) else begin
            errors++;
            $error("[TB] FAIL %s dut%0d timeout observed=%b expected=%0d", tag, k, oTo[k], mTo[k]);
         end
      end
   endtask

   // Drive inputs at the falling edge, let one rising edge happen, check at the next falling edge.
   task automatic applyStimulus(input logic [3:0] r, input logic rs, input int cycles, input string tag);
      for (int c = 0; c < cycles; c++) begin
         req = r;
         rst = rs;
         @(posedge clk);
         modelStep(0, r, rs);
         modelStep(1, r, rs);
         @(negedge clk);
         checkOutput(tag);
      end
   endtask

   initial begin
      logic [3:0] rnd;
      checks = 0;
      errors = 0;
      mMaxHold[0] = 4;
      mMaxHold[1] = 0;
      for (int k = 0; k < 2; k++) begin
         mOwner[k] = -1; mPtr[k] = 0; mCnt[k] = 0; mIdx[k] = 0; mTo[k] = 0;
      end
      req = 4'b0000;
      rst = 1'b1;
      @(negedge clk);

      applyStimulus(4'b0000, 1'b1, 2, "reset");
      applyStimulus(4'b0000, 1'b0, 5, "idle");

      applyStimulus(4'b0100, 1'b0, 4, "single");
      applyStimulus(4'b0000, 1'b0, 2, "single_release");
      applyStimulus(4'b1000, 1'b0, 3, "after_single_ptr3");
      applyStimulus(4'b0000, 1'b0, 1, "gap");

      applyStimulus(4'b0000, 1'b1, 1, "reset2");
      applyStimulus(4'b1111, 1'b0, 20, "rotation");
      applyStimulus(4'b0000, 1'b0, 2, "rotation_end");

      applyStimulus(4'b1000, 1'b0, 3, "owner3");
      applyStimulus(4'b0000, 1'b0, 1, "owner3_release");
      applyStimulus(4'b1001, 1'b0, 3, "wrap");
      applyStimulus(4'b0000, 1'b0, 2, "wrap_end");

      applyStimulus(4'b0010, 1'b0, 4, "coincide_hold");
      applyStimulus(4'b0000, 1'b0, 2, "coincide_drop");

      applyStimulus(4'b0000, 1'b1, 1, "reset3");
      applyStimulus(4'b0100, 1'b0, 2, "grant2");
      applyStimulus(4'b1100, 1'b1, 1, "reset_mid");
      applyStimulus(4'b1100, 1'b0, 3, "after_reset");
      applyStimulus(4'b0000, 1'b0, 2, "after_reset_end");

      applyStimulus(4'b0001, 1'b0, 300, "hold0");
      applyStimulus(4'b0000, 1'b0, 2, "hold0_end");

      rnd = 4'b0000;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) rnd = 4'($urandom_range(0, 15));
         applyStimulus(rnd, ($urandom_range(0, 99) == 0), 1, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
